if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register. It generates the fetch PC, runs a
//  req/ack handshake to instruction ROM and buffers fetched 64-bit words. It presents
//  {pc, inst, valid} to the decode stage and honours decode's branch redirect with one delay slot.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset (bits [2:0] must be 0)
//  FIFO_DEPTH  2              prefetch buffer entries (power of 2, >=2)
//  INST_BYTES  8              PC increment per instruction
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous reset, active-low
//  stall_i        in   1   ctrl hold: IF/ID outputs frozen, no pop
//  branch_flag_i  in   1   decode: instruction in IF/ID is a taken branch
//  target_addr_i  in   32  decode: branch target
//  rom_req_o      out  1   fetch request
//  rom_addr_o     out  32  fetch address, stable while rom_req_o=1 and no ack yet
//  rom_ack_i      in   1   request accepted; rom_data_i valid this cycle
//  rom_data_i     in   64  instruction word
//  id_pc_o        out  32  PC of instruction presented to decode
//  id_inst_o      out  64  instruction presented to decode (64'h0 = NOP)
//  id_valid_o     out  1   id_inst_o is a real instruction
// BEHAVIOUR
//  Reset (async, rst=0):
//   - id_pc_o=0, id_inst_o=0, id_valid_o=0, rom_req_o=0, rom_addr_o=RESET_PC.
//   - FIFO empty, state=S_RUN, fetch_pc=RESET_PC, any in-flight request forgotten.
//   - rom_ack_i with no outstanding request is ignored.
//  ROM handshake:
//   - rom_req_o registered; address held until ack. Ack allowed in the same cycle as req
//     (min latency 1 clk) or any later cycle. A request is never withdrawn before ack.
//   - On ack: {rom_addr_o, rom_data_i} is pushed or dropped (see states). Back-to-back
//     requests next cycle are allowed.
//   - Issue only while occupancy + outstanding - pop_this_cycle < FIFO_DEPTH.
//  fetch_pc:
//   - +INST_BYTES per issued request, modulo 2^32 (32'hFFFF_FFF8 -> 0).
//   - Targets are taken with bits [2:0] forced to 0.
//  IF/ID register, each clk with stall_i=0:
//   - FIFO non-empty: pop head into id_* and set valid=1.
//   - Else load bubble (inst=0, valid=0, pc unchanged).
//   - stall_i=1: id_* hold; the FIFO may still fill.
//  Branch acceptance: branch_flag_i & id_valid_o & ~stall_i, with B=id_pc_o, D=B+8, T=target.
//   - Ignored while stall_i=1 (decode re-presents it).
//   - Ignored while state != S_RUN.
//   - Decode must deliver D next, then T; nothing after D on the sequential path is executed.
//  States:
//   S_RUN: sequential fetch. On branch acceptance, keep D only:
//    - D at FIFO head: popped this clk; flush the rest.
//      - No request outstanding: fetch_pc<=T, stay S_RUN.
//      - Request outstanding: fetch_pc<=T, mark it drop, go S_DRAIN.
//    - FIFO empty and D outstanding or not yet issued: latch T, go S_DS_WAIT.
//   S_DS_WAIT: issue/await D only. On ack of D: push D, fetch_pc<=T, go S_RUN.
//   S_DRAIN: rom_req_o held for the stale address. On its ack: drop data, issue T next, go S_RUN.
//  Simultaneous events:
//   - Push and pop in the same clk are both performed.
//   - A branch accepted in the ack cycle of a non-D word drops that word.
//  Full FIFO: no issue; the current request may complete only if a slot frees that clk.
// STRUCTURE
//  - Shared defines file: InstAddrBus, InstBus, ZeroWord, NOP encoding,
//    state codes IF_S_RUN / IF_S_DS_WAIT / IF_S_DRAIN.
//  - One sub-module: fetch_fifo (DEPTH x {pc[31:0], inst[63:0]}, push/pop/flush, count);
//    a flush asserted in the same clk as a push wins.
//  - Handshake, state machine and IF/ID register live in this module.
// TESTING
//  1 Reset release, zero-wait ROM (ack=req), inst=addr pattern -> id_pc 0,8,16,24 on
//    consecutive clks from the 2nd clk, valid=1, no bubbles.
//  2 ROM latency 3 clks -> one valid instruction every 3 clks, bubbles (valid=0, inst=0) between.
//  3 Branch at B=0x10, T=0x100, D prefetched -> decode sees 0x10, 0x18, 0x100;
//    0x20 is never valid at id_*.
//  4 Branch with FIFO empty, D in flight, latency 4 -> 0x18 delivered, then 0x100.
//    No request for 0x20 is issued after acceptance.
//  5 stall_i=1 for 5 clks with branch_flag_i=1 -> id_* constant, FIFO fills to 2,
//    rom_req_o=0 when full; after release the branch is taken once only.
//  6 Reset asserted mid-request (req=1, no ack), wrap test at RESET_PC=32'hFFFF_FFF0
//    -> outputs cleared immediately; PCs FFF0, FFF8, 0000_0000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, NOP encoding, fetch state codes and FIFO entry type
package if_fetch_pkg;
    localparam int InstAddrBus = 32;
    localparam int InstBus = 64;
    localparam logic [InstAddrBus-1:0] ZeroWord = '0;
    localparam logic [InstBus-1:0] NopInst = '0;
    typedef enum logic [1:0] {IF_S_RUN, IF_S_DS_WAIT, IF_S_DRAIN} if_state_e;
    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// fetch_fifo: prefetch buffer of {pc, inst} words; flush beats a same-cycle push
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0]   r_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end
    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: fetch PC generation, ROM req/ack handshake, prefetch buffer and IF/ID register
// with a one-instruction branch delay slot.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] INST_BYTES = 32'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] target_addr_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [63:0] rom_data_i,
    output logic [31:0] id_pc_o,
    output logic [63:0] id_inst_o,
    output logic        id_valid_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    if_state_e    r_state;
    logic         r_req, r_id_valid;
    logic [31:0]  r_addr, r_fetch_pc, r_target, r_id_pc;
    logic [63:0]  r_id_inst;
    logic         w_ack, w_pop, w_push, w_flush, w_br, w_room, w_issue, w_empty;
    logic [CW-1:0] w_cnt;
    logic [CW:0]  w_occ;
    logic [31:0]  w_tgt;
    fetch_entry_t w_head, w_in;

    assign w_ack   = rom_ack_i & r_req;
    assign w_empty = w_cnt == '0;
    assign w_pop   = ~stall_i & ~w_empty;
    assign w_br    = branch_flag_i & r_id_valid & ~stall_i & (r_state == IF_S_RUN);
    assign w_tgt   = target_addr_i & ~32'h7;
    // With the delay slot already buffered, everything behind it is wrong-path.
    assign w_flush = w_br & ~w_empty;
    assign w_push  = w_ack & (r_state != IF_S_DRAIN);
    assign w_in    = '{pc: r_addr, inst: rom_data_i};
    // The outstanding request already owns a slot, so a push can never overflow.
    assign w_occ   = {1'b0, w_cnt} + (CW+1)'(r_req) - (CW+1)'(w_pop);
    assign w_room  = w_occ < (CW+1)'(FIFO_DEPTH);
    assign w_issue = w_room & ~w_br & ((r_state == IF_S_RUN) ? (~r_req | w_ack)
                                      : (r_state == IF_S_DS_WAIT) & ~r_req);

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_in),
        .o_head  (w_head),
        .o_count (w_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IF_S_RUN;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_target   <= ZeroWord;
            r_id_pc    <= ZeroWord;
            r_id_inst  <= NopInst;
            r_id_valid <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req      <= 1'b1;
                r_addr     <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + INST_BYTES;
            end else if (w_ack) begin
                r_req <= 1'b0;
            end
            case (r_state)
                IF_S_RUN: if (w_br) begin
                    // Delay slot is either buffered or arriving right now.
                    if (!w_empty || w_ack) begin
                        r_fetch_pc <= w_tgt;
                        if (!w_empty && r_req && !w_ack) r_state <= IF_S_DRAIN;
                    end else begin
                        r_target <= w_tgt;
                        r_state  <= IF_S_DS_WAIT;
                    end
                end
                IF_S_DS_WAIT: if (w_ack) begin
                    r_fetch_pc <= r_target;
                    r_state    <= IF_S_RUN;
                end
                default: if (w_ack) r_state <= IF_S_RUN;
            endcase
            if (!stall_i) begin
                r_id_valid <= w_pop;
                r_id_inst  <= w_pop ? w_head.inst : NopInst;
                if (w_pop) r_id_pc <= w_head.pc;
            end
        end
    end

    assign rom_req_o  = r_req;
    assign rom_addr_o = r_addr;
    assign id_pc_o    = r_id_pc;
    assign id_inst_o  = r_id_inst;
    assign id_valid_o = r_id_valid;
endmodule
